// File: rtl/polyunit_seq.sv
// Address and mode sequencer for the polynomial unit: streams LOAD/UNLOAD and
// runs multi-pass NTT/INTT/BYPASS with write-back delayed by the butterfly latency.
module polyunit_seq #(
    parameter int ADDWID  = 5,
    parameter int STEPCYC = 8,
    parameter int PIPELAT = 16,
    parameter int PASSWID = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 i_mode,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic                       o_rd_en,
    output logic [ADDWID-1:0]          o_rd_addr,
    output logic [ADDWID+PASSWID-1:0]  o_rom_addr,
    output logic                       o_wr_en,
    output logic [ADDWID-1:0]          o_wr_addr,
    output logic                       o_wr_sel,
    output logic [1:0]                 o_but_sel,
    output logic [PASSWID-1:0]         o_pass_idx,
    output logic                       o_out_valid,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int N     = 2 ** ADDWID;
    localparam int STEPW = (STEPCYC > 1) ? $clog2(STEPCYC) : 1;
    localparam logic [ADDWID:0]    CNT_N     = (ADDWID+1)'(N);
    localparam logic [ADDWID:0]    CNT_LAST  = (ADDWID+1)'(N - 1);
    localparam logic [STEPW-1:0]   STEP_LAST = STEPW'(STEPCYC - 1);
    localparam logic [PASSWID-1:0] PASS_MAX  = {PASSWID{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_UNLOAD,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_runMode;
    logic [ADDWID:0]      r_rdCnt;
    logic [ADDWID:0]      r_wrCnt;
    logic [STEPW-1:0]     r_step;
    logic [PASSWID-1:0]   r_pass;
    logic [PIPELAT-1:0]   r_pipe;
    logic                 r_outValid;

    logic w_startOk;
    logic w_rdEn;
    logic w_wrEn;
    logic w_passEnd;
    logic w_lastPass;

    always_comb begin
        w_startOk = i_start && !i_abort && (i_mode <= 3'd4);
        w_rdEn    = ((r_state == S_RUN) && (r_step == '0) && (r_rdCnt < CNT_N)) ||
                    ((r_state == S_UNLOAD) && (r_rdCnt < CNT_N));
        // Abort kills any write still emerging from the butterfly pipeline.
        w_wrEn    = !i_abort && (((r_state == S_LOAD) && i_in_valid) ||
                                 ((r_state == S_RUN) && r_pipe[PIPELAT-1]));
        w_passEnd = (r_state == S_RUN) && w_wrEn && (r_wrCnt == CNT_LAST);
        case (r_runMode)
            2'd1:    w_lastPass = (r_pass == PASS_MAX);
            2'd2:    w_lastPass = (r_pass == '0);
            default: w_lastPass = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_startOk) begin
                    case (i_mode)
                        3'd0:    w_next = S_LOAD;
                        3'd4:    w_next = S_UNLOAD;
                        default: w_next = S_RUN;
                    endcase
                end
            end
            S_LOAD:   if (w_wrEn && (r_wrCnt == CNT_LAST)) w_next = S_FIN;
            S_RUN:    if (w_passEnd && w_lastPass) w_next = S_FIN;
            S_UNLOAD: if ((r_rdCnt == CNT_N) && r_outValid) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (i_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_runMode  <= 2'd0;
            r_rdCnt    <= '0;
            r_wrCnt    <= '0;
            r_step     <= '0;
            r_pass     <= '0;
            r_pipe     <= '0;
            r_outValid <= 1'b0;
        end else if ((r_state == S_IDLE) || (w_next == S_IDLE) || (w_next == S_FIN)) begin
            r_rdCnt    <= '0;
            r_wrCnt    <= '0;
            r_step     <= '0;
            r_pipe     <= '0;
            r_outValid <= 1'b0;
            r_runMode  <= i_mode[1:0];
            // INTT walks the passes downwards, so it starts from the top pass.
            r_pass     <= ((r_state == S_IDLE) && (w_next == S_RUN) && (i_mode == 3'd2)) ?
                          PASS_MAX : '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_wrCnt <= r_wrCnt + {{ADDWID{1'b0}}, w_wrEn};
                end
                S_RUN: begin
                    if (w_passEnd) begin
                        r_pass  <= (r_runMode == 2'd2) ? r_pass - 1'b1 : r_pass + 1'b1;
                        r_rdCnt <= '0;
                        r_wrCnt <= '0;
                        r_step  <= '0;
                        r_pipe  <= '0;
                    end else begin
                        r_step  <= (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
                        r_rdCnt <= r_rdCnt + {{ADDWID{1'b0}}, w_rdEn};
                        r_wrCnt <= r_wrCnt + {{ADDWID{1'b0}}, w_wrEn};
                        r_pipe  <= (r_pipe << 1) | PIPELAT'(w_rdEn);
                    end
                end
                S_UNLOAD: begin
                    r_rdCnt    <= r_rdCnt + {{ADDWID{1'b0}}, w_rdEn};
                    r_outValid <= w_rdEn;
                end
                default: begin
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_in_ready  = (r_state == S_LOAD);
        o_rd_en     = w_rdEn;
        o_rd_addr   = r_rdCnt[ADDWID-1:0];
        o_rom_addr  = {r_pass, r_rdCnt[ADDWID-1:0]};
        o_wr_en     = w_wrEn;
        o_wr_addr   = r_wrCnt[ADDWID-1:0];
        o_wr_sel    = (r_state == S_RUN);
        o_but_sel   = 2'd0;
        if (r_state == S_RUN) begin
            o_but_sel = (r_runMode == 2'd1) ? 2'd0 : (r_runMode == 2'd2) ? 2'd1 : 2'd2;
        end
        o_pass_idx  = r_pass;
        o_out_valid = r_outValid;
        o_busy      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_UNLOAD);
        o_done      = (r_state == S_FIN) && !i_abort;
    end

endmodule

// File: tb/tb_polyunit_seq.sv
// Randomised bench for polyunit_seq: expected traces are derived cycle by cycle
// from the operation timing rules (read/write slots per pass, load/unload windows).
module tb_polyunit_seq;

    localparam int ADDWID  = 5;
    localparam int STEPCYC = 8;
    localparam int PIPELAT = 16;
    localparam int PASSWID = 2;
    localparam int N       = 1 << ADDWID;
    localparam int PASSES  = 1 << PASSWID;
    localparam int PLEN    = STEPCYC * (N - 1) + PIPELAT + 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [2:0]                mode;
    logic                      start;
    logic                      abort;
    logic                      inValid;
    logic                      inReady;
    logic                      rdEn;
    logic [ADDWID-1:0]         rdAddr;
    logic [ADDWID+PASSWID-1:0] romAddr;
    logic                      wrEn;
    logic [ADDWID-1:0]         wrAddr;
    logic                      wrSel;
    logic [1:0]                butSel;
    logic [PASSWID-1:0]        passIdx;
    logic                      outValid;
    logic                      busy;
    logic                      done;

    int nVectors     = 0;
    int nMiscompares = 0;

    polyunit_seq #(
        .ADDWID (ADDWID),
        .STEPCYC(STEPCYC),
        .PIPELAT(PIPELAT),
        .PASSWID(PASSWID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (mode),
        .i_start    (start),
        .i_abort    (abort),
        .i_in_valid (inValid),
        .o_in_ready (inReady),
        .o_rd_en    (rdEn),
        .o_rd_addr  (rdAddr),
        .o_rom_addr (romAddr),
        .o_wr_en    (wrEn),
        .o_wr_addr  (wrAddr),
        .o_wr_sel   (wrSel),
        .o_but_sel  (butSel),
        .o_pass_idx (passIdx),
        .o_out_valid(outValid),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"},      32'(busy),     32'd0);
        checkOutput({tag, " done"},      32'(done),     32'd0);
        checkOutput({tag, " rd_en"},     32'(rdEn),     32'd0);
        checkOutput({tag, " wr_en"},     32'(wrEn),     32'd0);
        checkOutput({tag, " in_ready"},  32'(inReady),  32'd0);
        checkOutput({tag, " out_valid"}, 32'(outValid), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkIdle(tag);
        checkOutput({tag, " rd_addr"},  32'(rdAddr),  32'd0);
        checkOutput({tag, " rom_addr"}, 32'(romAddr), 32'd0);
        checkOutput({tag, " wr_addr"},  32'(wrAddr),  32'd0);
        checkOutput({tag, " wr_sel"},   32'(wrSel),   32'd0);
        checkOutput({tag, " but_sel"},  32'(butSel),  32'd0);
        checkOutput({tag, " pass_idx"}, 32'(passIdx), 32'd0);
    endtask

    function automatic int doneCycleOf(input int m);
        if (m == 4) return N + 2;
        if (m == 3) return 1 + PLEN;
        return 1 + PLEN * PASSES;
    endfunction

    // One operation from its start cycle (0) to the first idle cycle afterwards.
    task automatic applyStimulus(input logic [2:0] opMode, input int abortAt);
        int  loaded = 0;
        int  doneAt = doneCycleOf(int'(opMode));
        bit  finished = 0;
        bit  iv;
        bit  inRun;
        int  p, o;
        int  eRd, eRdAddr, eWr, eWrAddr, eWrSel, eBut, ePass, eOv, eBusy, eDone, eRdy;
        string tag;
        @(negedge clk);
        mode = opMode; start = 1'b1; abort = 1'b0; inValid = 1'b0;
        #1;
        checkIdle($sformatf("m%0d c0", opMode));
        for (int c = 1; !finished; c++) begin
            if (c > 5000) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL m%0d timeout: no completion after %0d cycles", opMode, c);
                break;
            end
            @(negedge clk);
            iv      = ($urandom_range(0, 9) < 7);
            inValid = iv;
            abort   = (c == abortAt);
            start   = (abortAt != 0 && c > abortAt) ? 1'b0 : 1'($urandom_range(0, 1));
            mode    = 3'($urandom_range(0, 7));
            {eRd, eRdAddr, eWr, eWrAddr, eWrSel, eBut, ePass, eOv, eBusy, eDone, eRdy} = '0;
            inRun = 0;
            if (abortAt != 0 && c > abortAt) begin
                finished = 1;
            end else begin
                case (opMode)
                    3'd0: begin
                        if (loaded < N) begin
                            eRdy = 1; eBusy = 1; eWr = int'(iv); eWrAddr = loaded;
                            if (iv) loaded++;
                        end else begin
                            eDone = 1; finished = 1;
                        end
                    end
                    3'd4: begin
                        eRd     = int'(c <= N);
                        eRdAddr = c - 1;
                        eOv     = int'(c >= 2 && c <= N + 1);
                        eBusy   = int'(c <= N + 1);
                        eDone   = int'(c == doneAt);
                        finished = (c == doneAt);
                    end
                    default: begin
                        if (c < doneAt) begin
                            inRun   = 1;
                            eBusy   = 1;
                            p       = (c - 1) / PLEN;
                            o       = (c - 1) % PLEN;
                            eRd     = int'((o % STEPCYC == 0) && (o / STEPCYC < N));
                            eRdAddr = o / STEPCYC;
                            eWr     = int'((o >= PIPELAT) && ((o - PIPELAT) % STEPCYC == 0) &&
                                           ((o - PIPELAT) / STEPCYC < N));
                            eWrAddr = (o - PIPELAT) / STEPCYC;
                            eWrSel  = 1;
                            eBut    = (opMode == 3'd1) ? 0 : (opMode == 3'd2) ? 1 : 2;
                            ePass   = (opMode == 3'd2) ? PASSES - 1 - p : p;
                        end else begin
                            eDone = 1; finished = 1;
                        end
                    end
                endcase
            end
            if (c == abortAt) begin
                eWr = 0; eDone = 0;
            end
            #1;
            tag = $sformatf("m%0d c%0d", opMode, c);
            checkOutput({tag, " rd_en"},     32'(rdEn),     32'(eRd));
            checkOutput({tag, " wr_en"},     32'(wrEn),     32'(eWr));
            checkOutput({tag, " in_ready"},  32'(inReady),  32'(eRdy));
            checkOutput({tag, " out_valid"}, 32'(outValid), 32'(eOv));
            checkOutput({tag, " busy"},      32'(busy),     32'(eBusy));
            checkOutput({tag, " done"},      32'(done),     32'(eDone));
            if (eRd != 0) checkOutput({tag, " rd_addr"}, 32'(rdAddr), 32'(eRdAddr));
            if (eWr != 0) begin
                checkOutput({tag, " wr_addr"}, 32'(wrAddr), 32'(eWrAddr));
                checkOutput({tag, " wr_sel"},  32'(wrSel),  32'(eWrSel));
            end
            if (inRun) begin
                checkOutput({tag, " but_sel"},  32'(butSel),  32'(eBut));
                checkOutput({tag, " pass_idx"}, 32'(passIdx), 32'(ePass));
                if (eRd != 0) checkOutput({tag, " rom_addr"}, 32'(romAddr), 32'(ePass * N + eRdAddr));
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; inValid = 1'b0;
        #1;
        checkIdle($sformatf("m%0d post", opMode));
    endtask

    initial begin
        int m;
        int ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; inValid = 1'b0; mode = 3'd0;
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkAllZero("after reset");

        applyStimulus(3'd0, 0);
        applyStimulus(3'd1, 0);
        applyStimulus(3'd2, 0);
        applyStimulus(3'd3, 0);
        applyStimulus(3'd4, 0);
        applyStimulus(3'd1, 100);

        for (int r = 5; r <= 7; r++) begin
            @(negedge clk);
            mode = 3'(r); start = 1'b1;
            #1;
            checkIdle($sformatf("reserved%0d start", r));
            @(negedge clk);
            start = 1'b0;
            #1;
            checkIdle($sformatf("reserved%0d after", r));
        end

        @(negedge clk);
        mode = 3'd1; start = 1'b1; abort = 1'b1;
        #1;
        checkIdle("start+abort");
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        checkIdle("start+abort after");

        @(negedge clk);
        mode = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; inValid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("midload busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        rst = 1'b0; inValid = 1'b0;
        #1;
        checkAllZero("async reset released");
        applyStimulus(3'd0, 0);

        repeat (8) begin
            m  = $urandom_range(0, 4);
            ab = 0;
            if ($urandom_range(0, 1) == 1) begin
                if (m == 0)      ab = $urandom_range(1, N);
                else if (m == 4) ab = $urandom_range(1, N + 1);
                else             ab = $urandom_range(1, doneCycleOf(m) - 1);
            end
            applyStimulus(3'(m), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
